// File: rtl/te_block_builder_pkg.sv
// Shared types for the E-trace instruction block builder: uop FIFO entry,
// ingress packet and block FSM state.
package te_block_builder_pkg;

`ifdef TRDB_ARCH64
   localparam int XLEN = 64;
`else
   localparam int XLEN = 32;
`endif
   localparam int IRETIRE_MAX_LEN = 32;
   localparam int ITYPE_LEN       = 3;
   localparam int CAUSE_LEN       = 5;
   localparam int PRIV_LEN        = 2;
   localparam int ILASTSIZE_LEN   = 1;

   typedef enum logic [ITYPE_LEN-1:0] {
      ITYPE_STD  = 3'd0,
      ITYPE_EXC  = 3'd1,
      ITYPE_INT  = 3'd2,
      ITYPE_ERET = 3'd3,
      ITYPE_NTB  = 3'd4,
      ITYPE_TB   = 3'd5,
      ITYPE_UIJ  = 3'd6
   } itype_e;

   typedef struct packed {
      logic                 valid;
      itype_e               itype;
      logic                 compressed;
      logic                 exception;
      logic                 interrupt;
      logic [CAUSE_LEN-1:0] cause;
      logic [XLEN-1:0]      tval;
      logic [XLEN-1:0]      pc;
      logic [PRIV_LEN-1:0]  priv;
   } fifo_entry_s;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } block_state_e;

   // iretire is carried at full width; narrower builds use the low bits.
   typedef struct packed {
      logic [IRETIRE_MAX_LEN-1:0] iretire;
      logic [ILASTSIZE_LEN-1:0]   ilastsize;
      itype_e                     itype;
      logic [XLEN-1:0]            iaddr;
      logic [CAUSE_LEN-1:0]       cause;
      logic [XLEN-1:0]            tval;
      logic [PRIV_LEN-1:0]        priv;
   } te_pkt_s;

endpackage

// File: rtl/te_block_builder.sv
// Merges consecutive retired uops into instruction blocks and emits one
// E-trace ingress packet per block through a one-entry registered stage.
module te_block_builder
   import te_block_builder_pkg::*;
#(
   parameter int IRETIRE_LEN = IRETIRE_MAX_LEN
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   entry_valid_i,
   input  fifo_entry_s            entry_i,
   output logic                   pop_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [IRETIRE_LEN-1:0] iretire_o,
   output logic                   ilastsize_o,
   output logic [ITYPE_LEN-1:0]   itype_o,
   output logic [XLEN-1:0]        iaddr_o,
   output logic [CAUSE_LEN-1:0]   cause_o,
   output logic [XLEN-1:0]        tval_o,
   output logic [PRIV_LEN-1:0]    priv_o
);

   localparam logic [IRETIRE_LEN:0] ACC_MAX = {1'b0, {IRETIRE_LEN{1'b1}}};

   block_state_e           state_q, state_d;
   logic [IRETIRE_LEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]        start_pc_q, start_pc_d;
   logic [PRIV_LEN-1:0]    priv_q, priv_d;
   logic                   last_size_q, last_size_d;
   te_pkt_s                pkt_q, pkt_d;
   logic                   valid_q;

   logic                   stage_free, take, trap, split, close;
   logic [IRETIRE_LEN-1:0] size;
   logic [IRETIRE_LEN:0]   acc_sum;

   assign stage_free = ~valid_q | ready_i;
   assign take       = entry_valid_i & stage_free;
   assign trap       = entry_i.exception | entry_i.interrupt;
   assign size       = entry_i.compressed ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
   assign acc_sum    = {1'b0, acc_q} + {1'b0, size};

   // A priv change or full accumulator closes the open block first; the
   // entry stays at the FIFO head and opens the next block.
   assign split = (state_q == COUNT) && entry_i.valid && !trap &&
                  ((entry_i.priv != priv_q) || (acc_sum > ACC_MAX));
   assign pop_o = take & ~split;

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      start_pc_d  = start_pc_q;
      priv_d      = priv_q;
      last_size_d = last_size_q;
      pkt_d       = '0;
      close       = 1'b0;

      if (take && entry_i.valid) begin
         if (trap) begin
            close       = 1'b1;
            pkt_d.itype = entry_i.exception ? ITYPE_EXC : ITYPE_INT;
            pkt_d.cause = entry_i.cause;
            pkt_d.tval  = entry_i.tval;
            if (state_q == COUNT) begin
               pkt_d.iretire   = IRETIRE_MAX_LEN'(acc_q);
               pkt_d.ilastsize = last_size_q;
               pkt_d.iaddr     = start_pc_q;
               pkt_d.priv      = priv_q;
            end else begin
               pkt_d.iaddr = entry_i.pc;
               pkt_d.priv  = entry_i.priv;
            end
            state_d = IDLE;
         end else if (split) begin
            close           = 1'b1;
            pkt_d.itype     = ITYPE_STD;
            pkt_d.iretire   = IRETIRE_MAX_LEN'(acc_q);
            pkt_d.ilastsize = last_size_q;
            pkt_d.iaddr     = start_pc_q;
            pkt_d.priv      = priv_q;
            state_d         = IDLE;
         end else if (state_q == IDLE) begin
            start_pc_d  = entry_i.pc;
            priv_d      = entry_i.priv;
            acc_d       = size;
            last_size_d = ~entry_i.compressed;
            if (entry_i.itype == ITYPE_STD) begin
               state_d = COUNT;
            end else begin
               close           = 1'b1;
               pkt_d.itype     = entry_i.itype;
               pkt_d.iretire   = IRETIRE_MAX_LEN'(size);
               pkt_d.ilastsize = ~entry_i.compressed;
               pkt_d.iaddr     = entry_i.pc;
               pkt_d.priv      = entry_i.priv;
            end
         end else begin
            acc_d       = acc_sum[IRETIRE_LEN-1:0];
            last_size_d = ~entry_i.compressed;
            if (entry_i.itype != ITYPE_STD) begin
               close           = 1'b1;
               pkt_d.itype     = entry_i.itype;
               pkt_d.iretire   = IRETIRE_MAX_LEN'(acc_sum[IRETIRE_LEN-1:0]);
               pkt_d.ilastsize = ~entry_i.compressed;
               pkt_d.iaddr     = start_pc_q;
               pkt_d.priv      = priv_q;
               state_d         = IDLE;
            end
         end
      end
   end

   // NOTE: state is updated only with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         start_pc_q  <= '0;
         priv_q      <= '0;
         last_size_q <= 1'b0;
         pkt_q       <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         start_pc_q  <= start_pc_d;
         priv_q      <= priv_d;
         last_size_q <= last_size_d;
         if (close) begin
            pkt_q   <= pkt_d;
            valid_q <= 1'b1;
         end else if (ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign valid_o     = valid_q;
   assign iretire_o   = pkt_q.iretire[IRETIRE_LEN-1:0];
   assign ilastsize_o = pkt_q.ilastsize;
   assign itype_o     = pkt_q.itype;
   assign iaddr_o     = pkt_q.iaddr;
   assign cause_o     = pkt_q.cause;
   assign tval_o      = pkt_q.tval;
   assign priv_o      = pkt_q.priv;

endmodule

// File: tb/tb_te_block_builder.sv
// Scoreboard bench for te_block_builder: a block-level reference model fills
// the expected queue at issue time; a monitor checks every transfer.
module tb_te_block_builder;
   import te_block_builder_pkg::*;

   localparam int          TB_IRETIRE_LEN = 4;
   localparam int unsigned ACC_LIMIT      = (1 << TB_IRETIRE_LEN) - 1;

   logic                      clk_i = 1'b0;
   logic                      rst_i;
   logic                      entry_valid_i;
   fifo_entry_s               entry_i;
   logic                      pop_o, valid_o, ready_i, ilastsize_o;
   logic [TB_IRETIRE_LEN-1:0] iretire_o;
   logic [ITYPE_LEN-1:0]      itype_o;
   logic [XLEN-1:0]           iaddr_o, tval_o;
   logic [CAUSE_LEN-1:0]      cause_o;
   logic [PRIV_LEN-1:0]       priv_o;

   te_block_builder #(.IRETIRE_LEN(TB_IRETIRE_LEN)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .entry_valid_i(entry_valid_i), .entry_i(entry_i),
      .pop_o(pop_o), .valid_o(valid_o), .ready_i(ready_i), .iretire_o(iretire_o),
      .ilastsize_o(ilastsize_o), .itype_o(itype_o), .iaddr_o(iaddr_o),
      .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_checks = 0;
   int          n_fail   = 0;
   fifo_entry_s stim_q[$];
   te_pkt_s     exp_q[$];
   te_pkt_s     rx_log[$];
   bit          drv_have = 0;
   int          ready_mode = 1;   // 0 random, 1 high, 2 low

   // reference model state: the currently open block
   bit                  m_open = 0;
   int unsigned         m_acc;
   logic [XLEN-1:0]     m_start;
   logic [PRIV_LEN-1:0] m_priv;
   bit                  m_last;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic te_pkt_s mk_pkt(input int unsigned ir, input bit ls, input itype_e it,
                                      input logic [XLEN-1:0] ia, input logic [CAUSE_LEN-1:0] c,
                                      input logic [XLEN-1:0] tv, input logic [PRIV_LEN-1:0] p);
      te_pkt_s r;
      r.iretire = ir; r.ilastsize = ls; r.itype = it; r.iaddr = ia;
      r.cause = c; r.tval = tv; r.priv = p;
      return r;
   endfunction

   function automatic fifo_entry_s mk_entry(input itype_e it, input logic [XLEN-1:0] pc,
                                            input logic [PRIV_LEN-1:0] p, input bit c);
      fifo_entry_s e;
      e = '0;
      e.valid = 1'b1; e.itype = it; e.pc = pc; e.priv = p; e.compressed = c;
      return e;
   endfunction

   function automatic te_pkt_s dut_pkt();
      return mk_pkt(32'(iretire_o), ilastsize_o, itype_e'(itype_o), iaddr_o, cause_o, tval_o, priv_o);
   endfunction

   // Block rules applied to the in-order entry stream.
   task automatic model_entry(input fifo_entry_s e);
      int unsigned sz;
      sz = e.compressed ? 1 : 2;
      if (!e.valid) return;
      if (e.exception || e.interrupt) begin
         exp_q.push_back(mk_pkt(m_open ? m_acc : 0, m_open ? m_last : 1'b0,
                                e.exception ? ITYPE_EXC : ITYPE_INT,
                                m_open ? m_start : e.pc, e.cause, e.tval,
                                m_open ? m_priv : e.priv));
         m_open = 0;
         return;
      end
      if (m_open && (e.priv != m_priv || m_acc + sz > ACC_LIMIT)) begin
         exp_q.push_back(mk_pkt(m_acc, m_last, ITYPE_STD, m_start, '0, '0, m_priv));
         m_open = 0;
      end
      if (!m_open) begin
         m_start = e.pc; m_priv = e.priv; m_acc = 0;
      end
      m_acc += sz;
      m_last = !e.compressed;
      if (e.itype == ITYPE_STD) m_open = 1;
      else begin
         exp_q.push_back(mk_pkt(m_acc, m_last, e.itype, m_start, '0, '0, m_priv));
         m_open = 0;
      end
   endtask

   task automatic issue(input fifo_entry_s e);
      model_entry(e);
      stim_q.push_back(e);
   endtask

   task automatic wait_drain(input string name);
      bit done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk_i); #4;
         done = (stim_q.size() == 0) && !drv_have && (exp_q.size() == 0) && !valid_o;
      end
      check({name, "_drain"}, done, 1'b1);
   endtask

   task automatic check_rx(input string name, input int idx, input te_pkt_s exp);
      if (idx < rx_log.size()) check(name, rx_log[idx], exp);
      else check({name, "_missing"}, rx_log.size(), idx + 1);
   endtask

   // driver: presents the head entry until it is popped, with random gaps
   initial begin : driver
      fifo_entry_s cur;
      entry_valid_i = 1'b0;
      entry_i = '0;
      forever begin
         @(negedge clk_i);
         if (!drv_have && stim_q.size() > 0) begin
            cur = stim_q.pop_front();
            drv_have = 1;
         end
         if (drv_have && $urandom_range(0, 4) != 0) begin
            entry_valid_i = 1'b1; entry_i = cur;
         end else begin
            entry_valid_i = 1'b0; entry_i = '0;
         end
         #4;
         if (entry_valid_i && pop_o && !rst_i) drv_have = 0;
      end
   end

   initial begin : ready_gen
      ready_i = 1'b0;
      forever begin
         @(negedge clk_i);
         case (ready_mode)
            0:       ready_i = ($urandom_range(0, 3) != 0);
            1:       ready_i = 1'b1;
            default: ready_i = 1'b0;
         endcase
      end
   end

   // monitor: compares every transfer and the hold behaviour of a stalled packet
   initial begin : monitor
      bit      held = 0;
      te_pkt_s held_pkt;
      forever begin
         @(negedge clk_i); #4;
         if (rst_i) held = 0;
         else begin
            if (held) begin
               check("hold_valid", valid_o, 1'b1);
               check("hold_stable", dut_pkt(), held_pkt);
            end
            if (valid_o && ready_i) begin
               if (exp_q.size() == 0) check("unexpected_pkt", dut_pkt(), '0);
               else check("pkt", dut_pkt(), exp_q.pop_front());
               rx_log.push_back(dut_pkt());
            end
            held = valid_o && !ready_i;
            held_pkt = dut_pkt();
            if (held) check("hold_no_pop", pop_o, 1'b0);
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      fifo_entry_s e;
      int k;
      rst_i = 1'b1;
      #1;
      check("reset_valid", valid_o, 1'b0);
      check("reset_pkt", dut_pkt(), '0);
      check("reset_pop", pop_o, 1'b0);
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;

      // three 32-bit STD then TB
      rx_log.delete();
      for (int i = 0; i < 3; i++) issue(mk_entry(ITYPE_STD, XLEN'(32'h100 + 4 * i), 2'd3, 1'b0));
      issue(mk_entry(ITYPE_TB, XLEN'(32'h10C), 2'd3, 1'b0));
      wait_drain("std_tb");
      check_rx("std_tb_pkt", 0, mk_pkt(8, 1'b1, ITYPE_TB, XLEN'(32'h100), '0, '0, 2'd3));

      // exception from IDLE
      rx_log.delete();
      e = mk_entry(ITYPE_STD, XLEN'(32'h200), 2'd3, 1'b0);
      e.exception = 1'b1; e.cause = 5'd2; e.tval = XLEN'(32'hDEAD);
      issue(e);
      wait_drain("exc_idle");
      check_rx("exc_idle_pkt", 0, mk_pkt(0, 1'b0, ITYPE_EXC, XLEN'(32'h200), 5'd2, XLEN'(32'hDEAD), 2'd3));
      check("exc_idle_count", rx_log.size(), 1);

      // priv change splits a block
      rx_log.delete();
      issue(mk_entry(ITYPE_STD, XLEN'(32'h300), 2'd3, 1'b1));
      issue(mk_entry(ITYPE_STD, XLEN'(32'h302), 2'd1, 1'b0));
      issue(mk_entry(ITYPE_TB, XLEN'(32'h306), 2'd1, 1'b0));
      wait_drain("priv");
      check_rx("priv_first", 0, mk_pkt(1, 1'b0, ITYPE_STD, XLEN'(32'h300), '0, '0, 2'd3));
      check_rx("priv_second", 1, mk_pkt(4, 1'b1, ITYPE_TB, XLEN'(32'h302), '0, '0, 2'd1));

      // encoder stall after NTB close
      rx_log.delete();
      ready_mode = 2;
      issue(mk_entry(ITYPE_NTB, XLEN'(32'h500), 2'd3, 1'b0));
      issue(mk_entry(ITYPE_TB, XLEN'(32'h600), 2'd3, 1'b1));
      k = 0;
      while (!valid_o && k < 50) begin @(negedge clk_i); #4; k++; end
      check("stall_valid_seen", valid_o, 1'b1);
      repeat (5) @(negedge clk_i);
      #4;
      check("stall_iaddr", iaddr_o, XLEN'(32'h500));
      check("stall_pop", pop_o, 1'b0);
      ready_mode = 1;
      wait_drain("stall");
      check_rx("stall_second", 1, mk_pkt(1, 1'b0, ITYPE_TB, XLEN'(32'h600), '0, '0, 2'd3));

      // accumulator overflow with a 4-bit iretire
      rx_log.delete();
      for (int i = 0; i < 9; i++) issue(mk_entry(ITYPE_STD, XLEN'(32'h400 + 4 * i), 2'd3, 1'b0));
      issue(mk_entry(ITYPE_TB, XLEN'(32'h424), 2'd3, 1'b0));
      wait_drain("ovf");
      check_rx("ovf_first", 0, mk_pkt(14, 1'b1, ITYPE_STD, XLEN'(32'h400), '0, '0, 2'd3));
      check_rx("ovf_second", 1, mk_pkt(6, 1'b1, ITYPE_TB, XLEN'(32'h41C), '0, '0, 2'd3));

      // reset in the middle of a block (acc = 6)
      for (int i = 0; i < 3; i++) issue(mk_entry(ITYPE_STD, XLEN'(32'h800 + 4 * i), 2'd3, 1'b0));
      wait_drain("pre_reset");
      @(negedge clk_i); #2;
      rst_i = 1'b1;
      #1;
      check("midrst_valid", valid_o, 1'b0);
      check("midrst_pkt", dut_pkt(), '0);
      m_open = 0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (10) @(negedge clk_i);
      #4;
      check("postrst_valid", valid_o, 1'b0);
      rx_log.delete();
      issue(mk_entry(ITYPE_TB, XLEN'(32'h700), 2'd3, 1'b0));
      wait_drain("postrst");
      check_rx("postrst_pkt", 0, mk_pkt(2, 1'b1, ITYPE_TB, XLEN'(32'h700), '0, '0, 2'd3));

      // randomized stream
      ready_mode = 0;
      for (int i = 0; i < 400; i++) begin
         int sel;
         e = '0;
         e.valid = ($urandom_range(0, 99) >= 5);
         sel = $urandom_range(0, 9);
         e.itype = (sel < 6) ? ITYPE_STD : (sel == 6) ? ITYPE_NTB : (sel == 7) ? ITYPE_TB :
                   (sel == 8) ? ITYPE_UIJ : ITYPE_ERET;
         e.compressed = 1'($urandom_range(0, 1));
         e.priv = ($urandom_range(0, 7) == 0) ? 2'd1 : 2'd3;
         e.pc = XLEN'($urandom & 32'hFFFF_FFFE);
         e.exception = ($urandom_range(0, 19) == 0);
         e.interrupt = ($urandom_range(0, 24) == 0);
         e.cause = 5'($urandom_range(0, 31));
         e.tval = XLEN'($urandom);
         issue(e);
      end
      issue(mk_entry(ITYPE_TB, XLEN'(32'h900), 2'd3, 1'b0));
      ready_mode = 1;
      wait_drain("random");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/te_block_builder.md
Name: te_block_builder

Overview:
- Reads uop entries (fifo_entry_s) from the uop FIFO, one per cycle.
- Merges consecutive retired standard instructions into a single instruction block.
- Emits one E-trace ingress packet per block (iretire/itype/iaddr/ilastsize/cause/tval/priv) toward the trace encoder.
- Sits between the uop FIFO read port and the trace encoder ingress, with a one-entry registered output stage.

Parameters:
- XLEN, 32, address/tval width (64 when TRDB_ARCH64 is defined).
- IRETIRE_LEN, 32, width of the iretire count in halfwords.
- ITYPE_LEN, 3, itype width.
- CAUSE_LEN, 5, cause width.
- PRIV_LEN, 2, privilege width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- entry_valid_i  in  1  uop FIFO not empty.
- entry_i  in  fifo_entry_s  head entry of the uop FIFO.
- pop_o  out  1  consume head entry this cycle.
- valid_o  out  1  ingress packet valid.
- ready_i  in  1  encoder accepts the packet (transfer = valid_o & ready_i).
- iretire_o  out  IRETIRE_LEN  halfwords retired in the block.
- ilastsize_o  out  1  last instruction size (0 = 16-bit, 1 = 32-bit).
- itype_o  out  ITYPE_LEN  itype_e of the block-closing event.
- iaddr_o  out  XLEN  address of the first instruction in the block, or the trap pc for an empty block.
- cause_o  out  CAUSE_LEN  trap cause, valid for EXC/INT.
- tval_o  out  XLEN  trap value, valid for EXC/INT.
- priv_o  out  PRIV_LEN  privilege of the block.

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator cleared.
- Entries with entry_i.valid = 0 are popped and ignored.
- Output stage is "free" when valid_o = 0, or when ready_i = 1 in the same cycle.
- pop_o = entry_valid_i & output stage free. There is no combinational path from ready_i to valid_o.
- Instruction size: size = 1 halfword if compressed, else 2. ilastsize_o = ~compressed of the last counted instruction.
- IDLE, on a popped retired entry:
  - Latch iaddr = pc, priv = priv, acc = size.
  - If itype == STD, go to COUNT.
  - Otherwise (NTB/TB/UIJ/ERET), close the block with that itype and acc.
- COUNT, on a popped STD entry with the same priv and no overflow: acc += size; stay in COUNT.
- COUNT, on a popped entry with itype NTB/TB/UIJ/ERET: acc += size; close with that itype; go to IDLE.
- Exception/interrupt entry (exception or interrupt set):
  - The trapping instruction is not counted.
  - Close with itype EXC (exception) or INT (interrupt; exception takes precedence if both are set).
  - Set cause_o/tval_o from the entry.
  - In COUNT: iretire = acc, iaddr = block start.
  - In IDLE: iretire = 0, iaddr = entry pc.
- Priv change: in COUNT, if entry priv != block priv:
  - Close the current block with itype STD and do not pop.
  - Go to IDLE; the entry starts a new block on a later cycle.
- Overflow: in COUNT, if acc + size > 2^IRETIRE_LEN - 1, close the current block with itype STD and do not pop.
- Close: registers the packet into the output stage with valid_o = 1 on the next clock edge. Latency is one cycle from the popping edge.
- Output hold: packet fields are held stable while valid_o & ~ready_i. Nothing is popped while the stage is held.
- valid_o clears after a transfer unless a new close happens in the same cycle (back-to-back closes are allowed).
- No output is produced for a block that is still counting. Idle gaps (entry_valid_i = 0) do not close a block.
- Reset asserted mid-block: the partial block is discarded and valid_o drops immediately.

Decomposition:
- Add to the shared package:
  - te_pkt_s: packed struct of the output fields.
  - block_state_e: IDLE = 0, COUNT = 1.
  - ILASTSIZE_LEN = 1.
- itype_e and fifo_entry_s are reused unchanged.
- No sub-module; the FSM, accumulator and output register live in one module.

Test Plan:
- Three 32-bit STD at pc 0x100, 0x104, 0x108, then TB at 0x10C, all priv 3 → one packet: iretire 8, iaddr 0x100, itype TB(5), ilastsize 1, priv 3.
- IDLE, exception entry pc 0x200, cause 2, tval 0xDEAD → packet: iretire 0, iaddr 0x200, itype EXC(1), cause 2, tval 0xDEAD; no STD block emitted.
- Compressed STD at 0x300, then priv change 3→1 STD at 0x302 → first packet: iretire 1, iaddr 0x300, itype STD, ilastsize 0. Second entry is popped a cycle later and opens a new block.
- ready_i held low 5 cycles after a NTB close → valid_o and fields stable; pop_o = 0 throughout. The next packet follows the cycle after ready_i rises.
- IRETIRE_LEN = 4, nine 32-bit STD (acc would reach 18) → first packet iretire 14, itype STD; the 8th entry opens the next block.
- Assert rst_i during COUNT with acc = 6 → outputs 0 immediately; no packet emitted after release.
